iob_sort_collector: RTL and testbench

- Downstream neighbour of the input-address sequencer that issues IO-buffer reads and the end-of-pieces pulse to the NPE.
- Captures each word returned by the IO buffer, one word per read enable, after a fixed read latency.
- Keeps the words insertion-sorted, descending, in a register array, and tracks the arrival index of each word.
- On the end-of-pieces pulse, waits for in-flight reads to land, then streams the sorted entries to the NPE over a valid/ready handshake.

---
 rtl/iob_sort_collector.sv | 163 ++++++++++++++++
 tb/tb_iob_sort_collector.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/iob_sort_collector.sv
// Captures IO-buffer read words, keeps the top DEPTH insertion-sorted (descending,
// stable on ties) with arrival indices, and streams them to the NPE after piece end.

module iob_sort_lane #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 8
) (
  input  logic              vld,
  input  logic              ge_up,
  input  logic [DATA_W-1:0] cur_d,
  input  logic [DATA_W-1:0] up_d,
  input  logic [DATA_W-1:0] new_d,
  input  logic [IDX_W-1:0]  cur_i,
  input  logic [IDX_W-1:0]  up_i,
  input  logic [IDX_W-1:0]  new_i,
  output logic              ge,
  output logic [DATA_W-1:0] nxt_d,
  output logic [IDX_W-1:0]  nxt_i
);
  // ge is a prefix over the sorted slots, so the first non-ge slot takes the new word
  assign ge = vld && (cur_d >= new_d);

  always_comb begin
    nxt_d = up_d;
    nxt_i = up_i;
    if (ge) begin
      nxt_d = cur_d;
      nxt_i = cur_i;
    end else if (ge_up) begin
      nxt_d = new_d;
      nxt_i = new_i;
    end
  end
endmodule

module iob_sort_collector #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_rd_en,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_piece_end,
  output logic [DATA_W-1:0] o_data,
  output logic [IDX_W-1:0]  o_index,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_done,
  output logic              o_overflow,
  output logic              o_busy
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int DC = $clog2(RD_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, EMIT} state_t;
  state_t state, nstate;

  logic [DEPTH-1:0][DATA_W-1:0] ent_d, nxt_d, up_d;
  logic [DEPTH-1:0][IDX_W-1:0]  ent_i, nxt_i, up_i;
  logic [DEPTH-1:0]             ge, ge_up, slot_vld;
  logic [CW-1:0]                cnt;
  logic [PW-1:0]                ptr;
  logic [IDX_W-1:0]             arr;
  logic [DC-1:0]                drain_cnt;
  logic [RD_LATENCY-1:0]        rd_pipe;
  logic [RD_LATENCY:0]          rd_sh;
  logic                         capture, hs;

  assign rd_sh   = {rd_pipe, i_rd_en};
  assign capture = rd_pipe[RD_LATENCY-1] && (state == COLLECT || state == DRAIN) && !i_start;
  assign hs      = o_valid && i_ready;

  for (genvar g = 0; g < DEPTH; g++) begin : g_lane
    assign slot_vld[g] = CW'(g) < cnt;
    if (g == 0) begin : g_head
      assign ge_up[g] = 1'b1;
      assign up_d[g]  = i_rd_data;
      assign up_i[g]  = arr;
    end else begin : g_body
      assign ge_up[g] = ge[g-1];
      assign up_d[g]  = ent_d[g-1];
      assign up_i[g]  = ent_i[g-1];
    end
    iob_sort_lane #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_lane (
      .vld(slot_vld[g]), .ge_up(ge_up[g]),
      .cur_d(ent_d[g]), .up_d(up_d[g]), .new_d(i_rd_data),
      .cur_i(ent_i[g]), .up_i(up_i[g]), .new_i(arr),
      .ge(ge[g]), .nxt_d(nxt_d[g]), .nxt_i(nxt_i[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (i_start) nstate = COLLECT;
    else begin
      case (state)
        IDLE:    nstate = IDLE;
        COLLECT: if (i_piece_end) nstate = DRAIN;
        DRAIN:   if (drain_cnt == '0) nstate = EMIT;
        EMIT:    if (cnt == '0 || (hs && o_last)) nstate = IDLE;
        default: nstate = IDLE;
      endcase
    end
  end

  always_comb begin
    o_valid = (state == EMIT) && (cnt != '0);
    o_last  = o_valid && (CW'(ptr) == cnt - CW'(1));
    o_data  = o_valid ? ent_d[ptr] : '0;
    o_index = o_valid ? ent_i[ptr] : '0;
    o_done  = !i_start && (state == EMIT) && ((cnt == '0) || (hs && o_last));
    o_busy  = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_d      <= '0;
      ent_i      <= '0;
      cnt        <= '0;
      arr        <= '0;
      ptr        <= '0;
      drain_cnt  <= '0;
      rd_pipe    <= '0;
      o_overflow <= 1'b0;
    end else if (i_start) begin
      ent_d      <= '0;
      ent_i      <= '0;
      cnt        <= '0;
      arr        <= '0;
      ptr        <= '0;
      drain_cnt  <= '0;
      rd_pipe    <= '0;
      o_overflow <= 1'b0;
    end else begin
      rd_pipe <= rd_sh[RD_LATENCY-1:0];
      if (capture) begin
        ent_d <= nxt_d;
        ent_i <= nxt_i;
        arr   <= arr + IDX_W'(1);
        // a full array still takes a larger word (evicting the last); either way it overflowed
        if (cnt == CW'(DEPTH)) o_overflow <= 1'b1;
        else                   cnt <= cnt + CW'(1);
      end
      if (state == COLLECT && i_piece_end) drain_cnt <= DC'(RD_LATENCY);
      if (state == DRAIN) begin
        ptr <= '0;
        if (drain_cnt != '0) drain_cnt <= drain_cnt - DC'(1);
      end
      if (state == EMIT && hs) ptr <= ptr + PW'(1);
    end
  end
endmodule

// File: tb/tb_iob_sort_collector.sv
// Bench for iob_sort_collector: two instances (DEPTH16/lat1 and DEPTH4/lat2) share
// stimulus; emitted streams are compared to a stable top-N descending sort of the words.

module tb_iob_sort_collector;
  logic clk = 0, rst = 1, i_start = 0, i_rd_en = 0, i_piece_end = 0, i_ready = 0;
  logic [15:0] cur_w = 0, da = 0, db1 = 0, db = 0;
  logic [15:0] a_data, b_data;
  logic [7:0]  a_idx, b_idx;
  logic a_valid, a_last, a_done, a_ovf, a_busy;
  logic b_valid, b_last, b_done, b_ovf, b_busy;

  typedef struct packed {logic [15:0] d; logic [7:0] i; logic l;} ent_t;
  ent_t qa[$], qb[$];
  ent_t pa, pb;
  int   words[$], pend[$];
  int   done_a = 0, done_b = 0, total = 0, bad = 0;
  logic stall_a = 0, stall_b = 0;

  always #5 clk = ~clk;
  // read data returns 1 cycle later for A, 2 cycles later for B
  always @(posedge clk) begin da <= cur_w; db1 <= cur_w; db <= db1; end

  iob_sort_collector #(.DATA_W(16), .DEPTH(16), .IDX_W(8), .RD_LATENCY(1)) u_a (
    .clk(clk), .rst(rst), .i_start(i_start), .i_rd_en(i_rd_en), .i_rd_data(da),
    .i_piece_end(i_piece_end), .o_data(a_data), .o_index(a_idx), .o_valid(a_valid),
    .i_ready(i_ready), .o_last(a_last), .o_done(a_done), .o_overflow(a_ovf), .o_busy(a_busy));
  iob_sort_collector #(.DATA_W(16), .DEPTH(4), .IDX_W(8), .RD_LATENCY(2)) u_b (
    .clk(clk), .rst(rst), .i_start(i_start), .i_rd_en(i_rd_en), .i_rd_data(db),
    .i_piece_end(i_piece_end), .o_data(b_data), .o_index(b_idx), .o_valid(b_valid),
    .i_ready(i_ready), .o_last(b_last), .o_done(b_done), .o_overflow(b_ovf), .o_busy(b_busy));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc; @(posedge clk); #1; endtask

  always @(negedge clk) begin
    if (rst) begin stall_a = 0; stall_b = 0; end
    else begin
      if (stall_a) chk("hold_a", {a_valid, a_data, a_idx, a_last}, {1'b1, pa});
      if (stall_b) chk("hold_b", {b_valid, b_data, b_idx, b_last}, {1'b1, pb});
      if (a_valid && i_ready) begin
        qa.push_back({a_data, a_idx, a_last});
        if (a_last) chk("done_on_last_a", a_done, 1);
      end
      if (b_valid && i_ready) begin
        qb.push_back({b_data, b_idx, b_last});
        if (b_last) chk("done_on_last_b", b_done, 1);
      end
      if (a_done) done_a++;
      if (b_done) done_b++;
      stall_a = a_valid && !i_ready && !i_start;
      stall_b = b_valid && !i_ready && !i_start;
      pa = {a_data, a_idx, a_last};
      pb = {b_data, b_idx, b_last};
    end
  end

  task automatic clr_run;
    words.delete(); qa.delete(); qb.delete(); done_a = 0; done_b = 0;
  endtask

  task automatic do_start;
    i_start = 1; cyc; i_start = 0; clr_run;
  endtask

  task automatic fill_rand(input int n, input int maxv);
    pend.delete();
    repeat (n) pend.push_back($urandom_range(0, maxv));
  endtask

  // last read enable coincides with the piece-end pulse
  task automatic collect(input int n);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 2)) begin i_rd_en = 0; cur_w = 16'($urandom); cyc; end
      i_rd_en = 1; cur_w = 16'(pend[k]); words.push_back(pend[k]);
      i_piece_end = (k == n - 1);
      cyc;
    end
    if (n == 0) begin i_piece_end = 1; cyc; end
    i_rd_en = 0; i_piece_end = 0; cur_w = 16'($urandom);
  endtask

  // reference: stable descending sort of arrival list, keep first depth
  task automatic verify(input string tag, input ent_t q[$], input int depth, input logic ovf);
    int n, m, best;
    bit used[64];
    ent_t e;
    n = words.size();
    m = (n < depth) ? n : depth;
    for (int j = 0; j < 64; j++) used[j] = 0;
    chk({tag, "_count"}, 64'(q.size()), 64'(m));
    chk({tag, "_ovf"}, ovf, n > depth);
    for (int k = 0; k < m; k++) begin
      best = -1;
      for (int j = 0; j < n; j++)
        if (!used[j] && (best < 0 || words[j] > words[best])) best = j;
      used[best] = 1;
      e = {16'(words[best]), 8'(best), k == m - 1};
      if (k < q.size()) chk({tag, "_entry"}, q[k], e);
    end
  endtask

  task automatic emit(input int mode);
    int ph = 0;
    for (int c = 0; c < 400; c++) begin
      case (mode)
        0: i_ready = 1;
        1: i_ready = (ph % 4 == 0) || (ph % 4 == 3);
        default: i_ready = 1'($urandom_range(0, 1));
      endcase
      ph++;
      cyc;
      if (done_a > 0 && done_b > 0) break;
    end
    i_ready = 0;
    chk("emit_timeout", (done_a > 0) && (done_b > 0), 1);
    repeat (3) cyc;
    chk("done_once_a", 64'(done_a), 1);
    chk("done_once_b", 64'(done_b), 1);
    chk("idle_busy", {a_busy, b_busy}, 0);
    verify("a", qa, 16, a_ovf);
    verify("b", qb, 4, b_ovf);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a"}, {a_valid, a_data, a_idx, a_last, a_done, a_ovf, a_busy}, 0);
    chk({tag, "_b"}, {b_valid, b_data, b_idx, b_last, b_done, b_ovf, b_busy}, 0);
  endtask

  initial begin
    rst = 1; repeat (2) cyc;
    chk_zero("reset");
    rst = 0; cyc;

    do_start; pend = '{7, 3, 9, 3, 1}; collect(5); emit(0);
    chk("p1_first", {qa[0].d, qa[0].i}, {16'd9, 8'd2});

    do_start; pend = '{10, 20, 5, 30, 15, 25}; collect(6); emit(0);
    chk("p2_b_idx", {qb[0].i, qb[1].i, qb[2].i, qb[3].i}, {8'd3, 8'd5, 8'd1, 8'd4});
    chk("p2_b_ovf", b_ovf, 1);

    do_start; fill_rand(8, 7); collect(8); emit(1);

    do_start; collect(0); emit(0);

    // read issued while idle must not leak into the next collection
    i_rd_en = 1; cur_w = 16'd99; cyc; i_rd_en = 0;
    do_start; pend = '{4, 8, 2}; collect(3); emit(0);

    do_start; fill_rand(6, 15); collect(6); i_ready = 1;
    for (int c = 0; c < 50 && !a_valid; c++) cyc;
    chk("abort_reach_emit", a_valid, 1);
    cyc;
    i_start = 1; cyc; i_start = 0;
    chk("abort_valid", {a_valid, b_valid}, 0);
    chk("abort_busy", {a_busy, b_busy}, 2'b11);
    clr_run; i_ready = 0;
    fill_rand(4, 15); collect(4); emit(2);

    for (int r = 0; r < 4; r++) begin
      do_start; fill_rand($urandom_range(0, 20), 15); collect(pend.size());
      emit($urandom_range(0, 2));
    end

    do_start; i_rd_en = 1; cur_w = 16'd5; cyc; cyc;
    rst = 1; #1;
    chk_zero("rst_collect");
    i_rd_en = 0; cyc; rst = 0; cyc;
    do_start; fill_rand(5, 15); collect(5); emit(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
